// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch state encoding and Thumb branch-class opcode prefixes.
package cpu_pkg;
  typedef enum logic {FETCH, ISSUE} state_t;
  localparam logic [3:0] B_COND = 4'b1101;
  localparam logic [7:0] UDF    = 8'hDE;
  localparam logic [7:0] SVC    = 8'hDF;
  localparam logic [4:0] B      = 5'b11100;
  localparam logic [4:0] BL_HI  = 5'b11110;
  localparam logic [4:0] BL_LO  = 5'b11111;
endpackage

// File: rtl/branch_target.sv
// branch_target: sign-extend, shift and add for every Thumb branch target.
module branch_target (
  input  logic [31:0] pc,
  input  logic [31:0] bl_hi,
  input  logic [7:0]  imm8,
  input  logic [10:0] imm11,
  output logic [31:0] seq,
  output logic [31:0] cond_target,
  output logic [31:0] b_target,
  output logic [31:0] hi_target,
  output logic [31:0] lo_target
);
  logic [31:0] pc4;
  assign pc4         = pc + 32'd4;
  assign seq         = pc + 32'd2;
  assign cond_target = pc4 + {{23{imm8[7]}}, imm8, 1'b0};
  assign b_target    = pc4 + {{20{imm11[10]}}, imm11, 1'b0};
  assign hi_target   = pc4 + {{9{imm11[10]}}, imm11, 12'b0};
  assign lo_target   = bl_hi + {20'b0, imm11, 1'b0};
endmodule

// File: rtl/fetch_branch.sv
// fetch_branch: two-state Thumb fetch loop with branch, BL pairing, SVC and fault strobes.
module fetch_branch
  import cpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [15:0] i_imem_rdata,
  output logic [15:0] o_ir,
  output logic        o_ir_valid,
  input  logic        i_met,
  input  logic        i_ex_done,
  input  logic        i_pc_load,
  input  logic [31:0] i_pc_value,
  output logic [31:0] o_pc,
  output logic        o_lr_wr,
  output logic [31:0] o_lr,
  output logic        o_svc,
  output logic        o_fault
);
  state_t state, state_nx;
  logic [31:0] pc, bl_hi, pc_nx, seq, cond_t, b_t, hi_t, lo_t;
  logic bl_pending, retire, take;
  logic is_bcond, is_udf, is_svc, is_b, is_bl_hi, is_bl_lo;

  branch_target u_target (
    .pc(pc), .bl_hi(bl_hi), .imm8(o_ir[7:0]), .imm11(o_ir[10:0]),
    .seq(seq), .cond_target(cond_t), .b_target(b_t), .hi_target(hi_t), .lo_target(lo_t)
  );

  assign is_bcond = o_ir[15:12] == B_COND && o_ir[11:9] != 3'b111;
  assign is_udf   = o_ir[15:8] == UDF;
  assign is_svc   = o_ir[15:8] == SVC;
  assign is_b     = o_ir[15:11] == B;
  assign is_bl_hi = o_ir[15:11] == BL_HI;
  assign is_bl_lo = o_ir[15:11] == BL_LO;
  assign retire   = state == ISSUE && i_ex_done;
  assign take     = retire && !i_pc_load;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= FETCH;
      pc         <= '0;
      o_ir       <= '0;
      bl_pending <= 1'b0;
      bl_hi      <= '0;
      o_lr       <= '0;
      o_lr_wr    <= 1'b0;
      o_svc      <= 1'b0;
      o_fault    <= 1'b0;
    end else begin
      state   <= state_nx;
      o_lr_wr <= take && is_bl_lo && bl_pending;
      o_svc   <= take && is_svc;
      o_fault <= take && (is_udf || (is_bl_lo && !bl_pending));
      if (state == FETCH && i_imem_ack) o_ir <= i_imem_rdata;
      if (retire) begin
        pc         <= pc_nx;
        bl_pending <= take && is_bl_hi;
      end
      if (take && is_bl_hi) bl_hi <= hi_t;
      if (take && is_bl_lo && bl_pending) o_lr <= seq | 32'd1;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == FETCH && i_imem_ack) state_nx = ISSUE;
    if (retire) state_nx = FETCH;
  end

  always_comb begin
    pc_nx = i_pc_load                ? (i_pc_value & ~32'd1) :
            (is_bcond && i_met)      ? cond_t :
            is_b                     ? b_t :
            (is_bl_lo && bl_pending) ? lo_t : seq;
  end

  always_comb begin
    o_imem_req  = state == FETCH;
    o_ir_valid  = state == ISSUE;
    o_imem_addr = pc;
    o_pc        = pc + 32'd4;
  end
endmodule
